rom_burst_reader: RTL and testbench
===================================

// Module: rom_burst_reader
// PURPOSE
//  Burst read sequencer upstream of the 8x8 single-port ROM: on a start command it walks a run of
//  ROM addresses, drives the ROM enable/address, absorbs the ROM's 1-cycle registered read latency,
//  and presents the words as a valid/ready stream to the downstream consumer. Backpressure is
//  handled by a 2-entry output buffer so the ROM is never read faster than data can be accepted.
// PARAMETERS
//  ADDR_W   3   ROM address width; ROM depth = 2**ADDR_W
//  DATA_W   8   ROM data width
//  LEN_W    4   burst length field width (lengths 1..2**LEN_W-1)
// PORTS
//  i_clk        in   1        clock, all state updates on posedge
//  i_rst        in   1        reset, synchronous, active-high
//  i_start      in   1        start burst (sampled only in IDLE)
//  i_base_addr  in   ADDR_W   first ROM address of burst
//  i_len        in   LEN_W    number of words in burst; 0 = command ignored
//  o_busy       out  1        high from cycle after accepted start until o_done pulses
//  o_done       out  1        one-cycle pulse after the last word is accepted downstream
//  o_rom_en     out  1        ROM enable (drives ROM i_en)
//  o_rom_addr   out  ADDR_W   ROM address (drives ROM i_addr)
//  i_rom_data   in   DATA_W   ROM read data (ROM o_dout), valid 1 cycle after address issued
//  o_valid      out  1        output word valid
//  o_data       out  DATA_W   output word
//  o_last       out  1        marks final word of burst, qualified by o_valid
//  i_ready      in   1        downstream accepts word when o_valid && i_ready
// BEHAVIOUR
//  - Reset (i_rst=1 at posedge): state IDLE; o_busy, o_done, o_rom_en, o_valid, o_last = 0;
//    o_rom_addr = 0; o_data = 0; buffer count, in-flight flag, issue/accept counters = 0.
//  - FSM: IDLE -> RUN on i_start && i_len!=0 (base/len latched); RUN -> DRAIN when issued count
//    == len; DRAIN -> IDLE when last word accepted (o_done pulses that next cycle, busy drops with it).
//  - o_rom_en = 1 throughout RUN and DRAIN (ROM output is gated by enable; must stay high while the
//    in-flight read returns); 0 in IDLE.
//  - Issue rule: in RUN, an address is issued in cycle t iff (buffer count + in-flight) < 2, or
//    == 2 with a handshake in cycle t. Read data captured into buffer at t+1 from i_rom_data.
//  - Address increments by 1 per issue, wraps modulo 2**ADDR_W (e.g. 7 -> 0); len may exceed depth.
//  - Steady state with i_ready=1: one word per cycle; first o_valid 2 cycles after start accepted.
//  - Buffer: 2-entry FIFO, in-order; o_data/o_valid from head; o_last set on the word whose accept
//    index == len-1. Simultaneous capture and handshake: count unchanged, order preserved.
//  - o_data holds stable while o_valid && !i_ready (no change until handshake).
//  - i_start while busy: ignored, no effect on current burst. i_start with i_len=0: ignored.
//  - Reset mid-burst: abort immediately; outputs at reset values the following cycle; no o_done.
//  - Back-to-back: i_start in the o_done cycle is accepted (state already IDLE).
// TESTING
//  1. base=0,len=8,i_ready=1 -> o_data 00..07 on 8 consecutive cycles, o_last with 07, o_done next cycle.
//  2. base=6,len=4 -> 06,07,00,01 (address wrap), o_last with 01.
//  3. base=2,len=3, i_ready low 5 cycles after first valid -> 02 held stable, no word lost/duplicated,
//     o_rom_addr issues stop at 2 outstanding, then 03,04 stream out.
//  4. i_start pulses during busy and i_start with len=0 in IDLE -> no new burst, o_busy unaffected.
//  5. i_rst asserted mid-burst (after 3 words) -> next cycle o_valid=0,o_busy=0,o_rom_en=0,no o_done;
//     new burst base=5,len=2 after reset -> 05,06.
//  6. Random i_ready (50%), len=15, base=3 -> scoreboard sequence 03..07,00..07,00,01, single o_last.

Source files
------------

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//   Burst read sequencer in front of a single-port ROM with a 1-cycle
//   registered read. A start command latches a base address and a length.
//   The block then walks consecutive ROM addresses, wrapping modulo the ROM
//   depth, and delivers the returned words as a valid/ready stream. A
//   2-entry output buffer absorbs backpressure. A new address is issued only
//   when the buffer plus the read in flight leave room for the word, so no
//   word is ever dropped.
//
// Ports
//   i_clk        clock, all state on posedge
//   i_rst        synchronous active-high reset
//   i_start      start burst (sampled only while idle)
//   i_base_addr  first ROM address of the burst
//   i_len        number of words in the burst (0 = command ignored)
//   o_busy       high from the cycle after an accepted start until o_done
//   o_done       one-cycle pulse after the last word is accepted
//   o_rom_en     ROM enable, high for the whole burst
//   o_rom_addr   ROM address
//   i_rom_data   ROM read data, valid one cycle after the address
//   o_valid      output word valid
//   o_data       output word (buffer head)
//   o_last       final word of the burst, qualified by o_valid
//   i_ready      downstream accepts when o_valid && i_ready
module rom_burst_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  accepted_q;
  logic [ADDR_W-1:0] addr_q;
  logic              vld_p1;       // a ROM read issued last cycle returns now
  logic [1:0]        cnt_q;        // buffer occupancy, 0..2
  logic [DATA_W-1:0] buf0_q;       // buffer head
  logic [DATA_W-1:0] buf1_q;
  logic              done_q;

  logic              start_ok;
  logic              pop;
  logic              issue;
  logic              last_acc;
  logic [1:0]        outstanding;

  assign start_ok    = (state == S_IDLE) && i_start && (i_len != '0);
  assign pop         = (cnt_q != 2'd0) && i_ready;
  // buffered words plus the read in flight never exceed two
  assign outstanding = cnt_q + {1'b0, vld_p1};
  // A slot freed by this cycle's handshake can be refilled immediately,
  // which keeps one word per cycle flowing when i_ready stays high.
  assign issue       = (state == S_RUN) &&
                       ((outstanding < 2'd2) || ((outstanding == 2'd2) && pop));
  assign last_acc    = pop && (accepted_q == len_q - LEN_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    o_busy     = 1'b0;
    o_rom_en   = 1'b0;
    o_rom_addr = addr_q;
    o_valid    = (cnt_q != 2'd0);
    o_data     = buf0_q;
    o_last     = 1'b0;
    o_done     = done_q;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy   = 1'b1;
        o_rom_en = 1'b1;
        if (issue && (issued_q + LEN_W'(1) == len_q)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // enable stays high so the final in-flight read still returns
        o_busy   = 1'b1;
        o_rom_en = 1'b1;
        if (last_acc) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    o_last = o_valid && (accepted_q == len_q - LEN_W'(1));
  end

  // Stage p0: address issue and burst counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q      <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      vld_p1     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_acc;
      vld_p1 <= issue;
      if (start_ok) begin
        len_q      <= i_len;
        addr_q     <= i_base_addr;
        issued_q   <= '0;
        accepted_q <= '0;
      end
      if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + LEN_W'(1);
      end
      if (pop) accepted_q <= accepted_q + LEN_W'(1);
    end
  end

  // Stage p1: capture returned ROM data into the in-order output buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      case ({vld_p1, pop})
        2'b10: begin
          if (cnt_q == 2'd0) buf0_q <= i_rom_data;
          else               buf1_q <= i_rom_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // capture and handshake together: occupancy unchanged, order kept
          if (cnt_q == 2'd1) begin
            buf0_q <= i_rom_data;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= i_rom_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [LEN_W-1:0]  i_len;
  logic              o_busy;
  logic              o_done;
  logic              o_rom_en;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              i_ready;

  always #5 i_clk = ~i_clk;

  rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_rom_en(o_rom_en),
    .o_rom_addr(o_rom_addr), .i_rom_data(rom_dout), .o_valid(o_valid),
    .o_data(o_data), .o_last(o_last), .i_ready(i_ready)
  );

  // ROM model: word at address a is a; registered read, output gated by enable
  always_ff @(posedge i_clk) begin
    if (o_rom_en) rom_dout <= DATA_W'(o_rom_addr);
    else          rom_dout <= '0;
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  typedef struct {
    int base;
    int len;
    int exp_first;
    int exp_last;
    int exp_cyc;
  } vec_t;

  word_t exp_q[$];
  vec_t  tbl[6];
  int    n_vec = 0;
  int    n_err = 0;
  int    hs_cnt = 0;
  bit    rand_ready = 1'b0;
  bit    mdl_busy = 1'b0;
  bit    exp_done = 1'b0;
  bit    prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference model, evaluated mid-cycle with stable inputs and outputs
  task automatic mon();
    word_t w;
    bit    new_done;
    if (i_rst) begin
      exp_q.delete();
      mdl_busy   = 1'b0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    chk("busy", int'(o_busy), int'(mdl_busy));
    chk("rom_en", int'(o_rom_en), int'(mdl_busy));
    chk("done", int'(o_done), int'(exp_done));
    if (prev_stall) begin
      chk("hold_valid", int'(o_valid), 1);
      chk("hold_data", int'(o_data), int'(prev_data));
    end
    new_done = 1'b0;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_word");
      end else begin
        w = exp_q.pop_front();
        chk("data", int'(o_data), int'(w.data));
        chk("last", int'(o_last), int'(w.last));
        hs_cnt++;
        new_done = w.last;
      end
    end
    prev_stall = o_valid && !i_ready;
    prev_data  = o_data;
    exp_done   = new_done;
    if (!mdl_busy) begin
      if (i_start && i_len != 0) begin
        mdl_busy = 1'b1;
        for (int i = 0; i < int'(i_len); i++) begin
          w.data = DATA_W'((int'(i_base_addr) + i) % (1 << ADDR_W));
          w.last = (i == int'(i_len) - 1);
          exp_q.push_back(w);
        end
      end
    end else if (new_done) begin
      mdl_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    mon();
    @(posedge i_clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_burst(input int base, input int len);
    i_base_addr = ADDR_W'(base);
    i_len       = LEN_W'(len);
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!o_done && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!o_done) fail_now("timeout waiting for o_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int first;
    int fdata;
    int ldata;
    int hs0;

    tbl[0] = '{0, 8, 8'h00, 8'h07, 10};
    tbl[1] = '{6, 4, 8'h06, 8'h01, 6};
    tbl[2] = '{7, 1, 8'h07, 8'h07, 3};
    tbl[3] = '{5, 10, 8'h05, 8'h06, 12};
    tbl[4] = '{1, 15, 8'h01, 8'h07, 17};
    tbl[5] = '{4, 2, 8'h04, 8'h05, 4};

    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_rom_en", int'(o_rom_en), 0);
    chk("rst_rom_addr", int'(o_rom_addr), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_last", int'(o_last), 0);
    i_rst = 1'b0;
    tick();

    // Table: full-rate bursts, each started in the previous burst's done cycle
    for (int v = 0; v < 6; v++) begin
      start_burst(tbl[v].base, tbl[v].len);
      cyc = 0; first = -1; fdata = -1; ldata = -1;
      while (!o_done && cyc < 64) begin
        tick();
        cyc++;
        if (o_valid && first < 0) begin first = cyc; fdata = int'(o_data); end
        if (o_valid && o_last) ldata = int'(o_data);
      end
      chk("tbl_first_latency", first, 2);
      chk("tbl_first_data", fdata, tbl[v].exp_first);
      chk("tbl_last_data", ldata, tbl[v].exp_last);
      chk("tbl_done_cycle", cyc, tbl[v].exp_cyc);
    end
    tick();

    // Backpressure: ready low for 5 cycles after the first word
    i_ready = 1'b0;
    start_burst(2, 3);
    cyc = 0;
    while (!o_valid && cyc < 10) begin tick(); cyc++; end
    chk("bp_first_latency", cyc, 2);
    chk("bp_addr_at_first", int'(o_rom_addr), 4);
    repeat (5) begin
      tick();
      chk("bp_valid", int'(o_valid), 1);
      chk("bp_hold_data", int'(o_data), 2);
      chk("bp_addr_stalled", int'(o_rom_addr), 4);
    end
    i_ready = 1'b1;
    wait_done(20, cyc);
    chk("bp_queue_empty", exp_q.size(), 0);
    tick();

    // Start while busy and zero-length start are ignored
    start_burst(0, 6);
    tick();
    i_start = 1'b1; i_base_addr = 3'd3; i_len = 4'd5;
    tick();
    tick();
    i_start = 1'b0;
    chk("busy_during_restart", int'(o_busy), 1);
    wait_done(30, cyc);
    chk("ignore_queue_empty", exp_q.size(), 0);
    i_len = 4'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) begin
      tick();
      chk("len0_busy", int'(o_busy), 0);
      chk("len0_valid", int'(o_valid), 0);
    end

    // Reset in the middle of a burst
    hs0 = hs_cnt;
    start_burst(0, 8);
    cyc = 0;
    while (hs_cnt - hs0 < 3 && cyc < 20) begin tick(); cyc++; end
    if (hs_cnt - hs0 < 3) fail_now("timeout waiting for 3 words");
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_rom_en", int'(o_rom_en), 0);
    chk("midrst_done", int'(o_done), 0);
    chk("midrst_data", int'(o_data), 0);
    chk("midrst_rom_addr", int'(o_rom_addr), 0);
    repeat (3) begin
      tick();
      chk("midrst_no_done", int'(o_done), 0);
    end
    start_burst(5, 2);
    wait_done(20, cyc);
    chk("postrst_done_cycle", cyc, 4);
    chk("postrst_queue_empty", exp_q.size(), 0);
    tick();

    // Random backpressure
    rand_ready = 1'b1;
    start_burst(3, 15);
    wait_done(300, cyc);
    chk("rand_queue_empty", exp_q.size(), 0);
    for (int r = 0; r < 6; r++) begin
      start_burst(int'($urandom_range(0, 7)), int'($urandom_range(1, 15)));
      wait_done(300, cyc);
      chk("rand_burst_queue_empty", exp_q.size(), 0);
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
